// File: rtl/hazard_ctrl.sv
// hazard_ctrl
// Pipeline hazard controller for a five-stage in-order core. It classifies
// each cycle as memory wait, branch flush, load-use stall or no hazard and
// drives the pipeline-register write/flush controls in that same cycle.
// A watchdog moves the block into a sticky HALT state when the data memory
// fails to acknowledge for too long. Two saturating counters record stall
// and flush cycles.

module hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             MemRead_ex,
  input  logic [4:0]       rdAddr_ex,
  input  logic [4:0]       rs1Addr_id,
  input  logic [4:0]       rs2Addr_id,
  input  logic             rs1Used_id,
  input  logic             rs2Used_id,
  input  logic             BranchTaken_ex,
  input  logic             dmem_req,
  input  logic             dmem_ack,
  output logic             PCWrite,
  output logic             IFIDWrite,
  output logic             IDEXWrite,
  output logic             EXMEMWrite,
  output logic             IFIDFlush,
  output logic             IDEXFlush,
  output logic             MEMWBBubble,
  output logic [1:0]       cause,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             halt
);

  // Wait counter is wide enough to hold TIMEOUT itself; a zero TIMEOUT
  // still needs a one-bit counter so the width stays legal.
  localparam int WAIT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(TIMEOUT);

  localparam logic [1:0] CAUSE_NONE   = 2'd0;
  localparam logic [1:0] CAUSE_LOADUSE = 2'd1;
  localparam logic [1:0] CAUSE_BRANCH = 2'd2;
  localparam logic [1:0] CAUSE_MEMWAIT = 2'd3;

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    MEMWAIT = 2'b01,
    HALT    = 2'b10
  } state_t;

  state_t             state_r;
  logic [WAIT_W-1:0]  waitCnt_r;
  logic [CNT_W-1:0]   stallCnt_r;
  logic [CNT_W-1:0]   flushCnt_r;
  logic               halt_r;

  logic               memWait_s;
  logic               loadUse_s;
  logic               branch_s;
  logic               inHalt_s;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] value);
    if (value == {CNT_W{1'b1}}) begin
      satInc = value;
    end else begin
      satInc = value + CNT_W'(1);
    end
  endfunction

  // A source register conflicts with the load only when it is really read.
  function automatic logic srcHit(input logic used, input logic [4:0] src,
                                  input logic [4:0] dst);
    srcHit = used && (src == dst);
  endfunction

  // Register x0 never carries a value, so a load into x0 cannot create a hazard.
  assign loadUse_s = MemRead_ex && (rdAddr_ex != 5'd0) &&
                     (srcHit(rs1Used_id, rs1Addr_id, rdAddr_ex) ||
                      srcHit(rs2Used_id, rs2Addr_id, rdAddr_ex));

  // An ack arriving with the request completes the access without a stall.
  assign memWait_s = dmem_req && !dmem_ack;
  assign branch_s  = BranchTaken_ex;

  // While reset is asserted the controls already follow the RUN rules,
  // even if the registered state is still HALT.
  assign inHalt_s  = (state_r == HALT) && !rst;

  // Classify the cycle by priority (memory wait, branch, load-use) and drive
  // the pipeline-register controls for it.
  always_comb begin
    PCWrite     = 1'b1;
    IFIDWrite   = 1'b1;
    IDEXWrite   = 1'b1;
    EXMEMWrite  = 1'b1;
    IFIDFlush   = 1'b0;
    IDEXFlush   = 1'b0;
    MEMWBBubble = 1'b0;
    cause       = CAUSE_NONE;
    if (inHalt_s) begin
      // Whole pipeline frozen; inputs are ignored.
      PCWrite     = 1'b0;
      IFIDWrite   = 1'b0;
      IDEXWrite   = 1'b0;
      EXMEMWrite  = 1'b0;
      MEMWBBubble = 1'b1;
      cause       = CAUSE_NONE;
    end else if (memWait_s) begin
      // Freeze everything up to MEM; a pending branch is replayed later
      // because EX does not advance.
      PCWrite     = 1'b0;
      IFIDWrite   = 1'b0;
      IDEXWrite   = 1'b0;
      EXMEMWrite  = 1'b0;
      MEMWBBubble = 1'b1;
      cause       = CAUSE_MEMWAIT;
    end else if (branch_s) begin
      // Redirect fetch and squash the two wrong-path instructions.
      IFIDFlush   = 1'b1;
      IDEXFlush   = 1'b1;
      cause       = CAUSE_BRANCH;
    end else if (loadUse_s) begin
      // Hold IF and ID for one cycle and insert a bubble behind the load.
      PCWrite     = 1'b0;
      IFIDWrite   = 1'b0;
      IDEXFlush   = 1'b1;
      cause       = CAUSE_LOADUSE;
    end else begin
      cause       = CAUSE_NONE;
    end
  end

  // Control FSM with memory-wait watchdog and saturating performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= RUN;
      waitCnt_r  <= {WAIT_W{1'b0}};
      stallCnt_r <= {CNT_W{1'b0}};
      flushCnt_r <= {CNT_W{1'b0}};
      halt_r     <= 1'b0;
    end else begin
      case (state_r)
        RUN, MEMWAIT: begin
          if (memWait_s) begin
            if (waitCnt_r == WAIT_MAX) begin
              // TIMEOUT+1 consecutive wait cycles: give up on the memory.
              state_r <= HALT;
              halt_r  <= 1'b1;
            end else begin
              state_r   <= MEMWAIT;
              waitCnt_r <= waitCnt_r + WAIT_W'(1);
            end
          end else begin
            state_r   <= RUN;
            waitCnt_r <= {WAIT_W{1'b0}};
          end

          if ((cause == CAUSE_LOADUSE) || (cause == CAUSE_MEMWAIT)) begin
            stallCnt_r <= satInc(stallCnt_r);
          end else begin
            stallCnt_r <= stallCnt_r;
          end

          if (cause == CAUSE_BRANCH) begin
            flushCnt_r <= satInc(flushCnt_r);
          end else begin
            flushCnt_r <= flushCnt_r;
          end
        end
        HALT: begin
          // Sticky until reset; counters frozen.
          state_r <= HALT;
          halt_r  <= 1'b1;
        end
        default: begin
          // An illegal encoding is treated as a fault and parks the pipeline.
          state_r <= HALT;
          halt_r  <= 1'b1;
        end
      endcase
    end
  end

  assign state     = state_r;
  assign stall_cnt = stallCnt_r;
  assign flush_cnt = flushCnt_r;
  assign halt      = halt_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl: directed scenarios with literal expectations,
// followed by randomized traffic compared every cycle against a behavioural
// model of the hazard rules.

module tb_hazard_ctrl;

  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 2;
  localparam int SAT     = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             MemRead_ex;
  logic [4:0]       rdAddr_ex;
  logic [4:0]       rs1Addr_id;
  logic [4:0]       rs2Addr_id;
  logic             rs1Used_id;
  logic             rs2Used_id;
  logic             BranchTaken_ex;
  logic             dmem_req;
  logic             dmem_ack;
  logic             PCWrite;
  logic             IFIDWrite;
  logic             IDEXWrite;
  logic             EXMEMWrite;
  logic             IFIDFlush;
  logic             IDEXFlush;
  logic             MEMWBBubble;
  logic [1:0]       cause;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             halt;

  hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .MemRead_ex(MemRead_ex), .rdAddr_ex(rdAddr_ex),
    .rs1Addr_id(rs1Addr_id), .rs2Addr_id(rs2Addr_id),
    .rs1Used_id(rs1Used_id), .rs2Used_id(rs2Used_id),
    .BranchTaken_ex(BranchTaken_ex),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXWrite(IDEXWrite),
    .EXMEMWrite(EXMEMWrite), .IFIDFlush(IFIDFlush), .IDEXFlush(IDEXFlush),
    .MEMWBBubble(MEMWBBubble), .cause(cause), .state(state),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .halt(halt)
  );

  int tests = 0;
  int fails = 0;

  // Model state: 0 = running, 1 = waiting on memory, 2 = halted.
  int mState    = 0;
  int mWaitRun  = 0;   // consecutive memory-wait cycles seen so far
  int mStall    = 0;
  int mFlush    = 0;
  bit modelLive = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit luNow();
    return MemRead_ex && (rdAddr_ex != 5'd0) &&
           ((rs1Used_id && (rs1Addr_id == rdAddr_ex)) ||
            (rs2Used_id && (rs2Addr_id == rdAddr_ex)));
  endfunction

  function automatic bit haltNow();
    return (mState == 2) && !rst;
  endfunction

  function automatic int expCause();
    if (haltNow()) return 0;
    if (dmem_req && !dmem_ack) return 3;
    if (BranchTaken_ex) return 2;
    if (luNow()) return 1;
    return 0;
  endfunction

  // {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, IFIDFlush, IDEXFlush, MEMWBBubble}
  function automatic logic [6:0] expCtrl();
    if (haltNow()) return 7'b0000001;
    case (expCause())
      3:       return 7'b0000001;
      2:       return 7'b1111110;
      1:       return 7'b0011010;
      default: return 7'b1111000;
    endcase
  endfunction

  // Advance the behavioural model on each rising edge using the inputs it saw.
  always @(posedge clk) begin
    int c;
    c = expCause();
    if (rst) begin
      mState = 0; mWaitRun = 0; mStall = 0; mFlush = 0;
      modelLive = 1'b1;
    end else if (mState != 2) begin
      if (c == 1 || c == 3) mStall = (mStall < SAT) ? mStall + 1 : SAT;
      if (c == 2) mFlush = (mFlush < SAT) ? mFlush + 1 : SAT;
      if (c == 3) begin
        mWaitRun++;
        mState = (mWaitRun == TIMEOUT + 1) ? 2 : 1;
      end else begin
        mWaitRun = 0;
        mState = 0;
      end
    end
  end

  // Compare every output with the model away from the active edge.
  always @(negedge clk) begin
    if (modelLive) begin
      chk("ctrl", 32'({PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite,
                       IFIDFlush, IDEXFlush, MEMWBBubble}), 32'(expCtrl()));
      chk("cause", 32'(cause), 32'(expCause()));
      chk("state", 32'(state), 32'(mState));
      chk("halt", 32'(halt), 32'(mState == 2));
      chk("stall_cnt", 32'(stall_cnt), 32'(mStall));
      chk("flush_cnt", 32'(flush_cnt), 32'(mFlush));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    MemRead_ex = 1'b0; rdAddr_ex = 5'd0; rs1Addr_id = 5'd0; rs2Addr_id = 5'd0;
    rs1Used_id = 1'b0; rs2Used_id = 1'b0; BranchTaken_ex = 1'b0;
    dmem_req = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic setLU();
    MemRead_ex = 1'b1; rdAddr_ex = 5'd5; rs2Addr_id = 5'd5; rs2Used_id = 1'b1;
    rs1Addr_id = 5'd7; rs1Used_id = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    cyc(); cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_halt", 32'(halt), 32'd0);
    chk("reset_stall", 32'(stall_cnt), 32'd0);
    chk("reset_flush", 32'(flush_cnt), 32'd0);

    // Load-use stall and its non-triggering variants.
    cyc(); setLU();
    @(negedge clk);
    chk("lu_pcwrite", 32'(PCWrite), 32'd0);
    chk("lu_ifidwrite", 32'(IFIDWrite), 32'd0);
    chk("lu_idexflush", 32'(IDEXFlush), 32'd1);
    chk("lu_cause", 32'(cause), 32'd1);
    cyc(); rdAddr_ex = 5'd0; rs2Addr_id = 5'd0;
    @(negedge clk);
    chk("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    chk("x0_cause", 32'(cause), 32'd0);
    chk("x0_pcwrite", 32'(PCWrite), 32'd1);
    cyc(); rdAddr_ex = 5'd5; rs2Addr_id = 5'd5; rs2Used_id = 1'b0;
    @(negedge clk);
    chk("unused_cause", 32'(cause), 32'd0);

    // Load-use together with a taken branch: branch wins.
    cyc(); rs2Used_id = 1'b1; BranchTaken_ex = 1'b1;
    @(negedge clk);
    chk("br_ifidflush", 32'(IFIDFlush), 32'd1);
    chk("br_idexflush", 32'(IDEXFlush), 32'd1);
    chk("br_pcwrite", 32'(PCWrite), 32'd1);
    chk("br_cause", 32'(cause), 32'd2);
    cyc(); idle();
    @(negedge clk);
    chk("br_flush_cnt", 32'(flush_cnt), 32'd1);
    chk("br_stall_cnt", 32'(stall_cnt), 32'd1);

    // Three memory-wait cycles, then ack.
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0; dmem_req = 1'b1; dmem_ack = 1'b0;
    @(negedge clk);
    chk("mw1_bubble", 32'(MEMWBBubble), 32'd1);
    chk("mw1_state", 32'(state), 32'd0);
    chk("mw1_cause", 32'(cause), 32'd3);
    cyc(); @(negedge clk);
    chk("mw2_state", 32'(state), 32'd1);
    chk("mw2_pcwrite", 32'(PCWrite), 32'd0);
    cyc(); @(negedge clk);
    chk("mw3_state", 32'(state), 32'd1);
    cyc(); dmem_ack = 1'b1;
    @(negedge clk);
    chk("ack_cause", 32'(cause), 32'd0);
    chk("ack_pcwrite", 32'(PCWrite), 32'd1);
    cyc(); idle();
    @(negedge clk);
    chk("mw_done_state", 32'(state), 32'd0);
    chk("mw_stall_cnt", 32'(stall_cnt), 32'd3);

    // Watchdog: TIMEOUT+1 wait cycles lead to HALT in cycle 6.
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0; dmem_req = 1'b1; dmem_ack = 1'b0;
    repeat (4) cyc();
    @(negedge clk);
    chk("wd5_halt", 32'(halt), 32'd0);
    chk("wd5_state", 32'(state), 32'd1);
    cyc(); @(negedge clk);
    chk("wd6_halt", 32'(halt), 32'd1);
    chk("wd6_state", 32'(state), 32'd2);
    cyc(); dmem_ack = 1'b1; BranchTaken_ex = 1'b1;
    @(negedge clk);
    chk("halt_writes", 32'({PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite}), 32'd0);
    chk("halt_bubble", 32'(MEMWBBubble), 32'd1);
    chk("halt_cause", 32'(cause), 32'd0);
    cyc(); @(negedge clk);
    chk("halt_flush_frozen", 32'(flush_cnt), 32'd0);
    chk("halt_sticky", 32'(state), 32'd2);
    cyc(); rst = 1'b1;
    @(negedge clk);
    chk("rst_run_pcwrite", 32'(PCWrite), 32'd1);
    chk("rst_run_cause", 32'(cause), 32'd2);
    cyc(); rst = 1'b0; idle();
    @(negedge clk);
    chk("rst_halt_clear", 32'(halt), 32'd0);
    chk("rst_state_run", 32'(state), 32'd0);

    // Saturation with a two-bit counter, then reset during a memory wait.
    cyc(); setLU();
    repeat (5) cyc();
    idle();
    @(negedge clk);
    chk("sat_stall_cnt", 32'(stall_cnt), 32'd3);
    cyc(); dmem_req = 1'b1;
    cyc(); cyc();
    @(negedge clk);
    chk("pre_rst_memwait", 32'(state), 32'd1);
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0; idle();
    @(negedge clk);
    chk("mwrst_state", 32'(state), 32'd0);
    chk("mwrst_stall", 32'(stall_cnt), 32'd0);
    chk("mwrst_flush", 32'(flush_cnt), 32'd0);

    // Randomized traffic checked by the per-cycle compare process.
    for (int i = 0; i < 3000; i++) begin
      cyc();
      rst            = ($urandom_range(0, 99) < 2);
      MemRead_ex     = 1'($urandom_range(0, 1));
      rdAddr_ex      = 5'($urandom_range(0, 3));
      rs1Addr_id     = 5'($urandom_range(0, 3));
      rs2Addr_id     = 5'($urandom_range(0, 3));
      rs1Used_id     = 1'($urandom_range(0, 1));
      rs2Used_id     = 1'($urandom_range(0, 1));
      BranchTaken_ex = ($urandom_range(0, 4) == 0);
      dmem_req       = ($urandom_range(0, 9) < 6);
      dmem_ack       = ($urandom_range(0, 9) < 3);
    end
    cyc(); idle();
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
